// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (D/E, E/M, M/W): 1-cycle registered In -> Out, no comb path.
// Stall holds and refreshes valid operands from forwarding; Flush inserts a bubble and wins over Stall.
module pipe_stage_reg #(
    parameter int                 DATA_W   = 32,
    parameter int                 NUM_OPS  = 2,
    parameter int                 REG_W    = 5,
    parameter int                 CTRL_W   = 16,
    parameter int                 T_W      = 2,
    parameter int                 CNT_W    = 8,
    parameter logic [DATA_W-1:0]  PC_RESET = DATA_W'(32'h0000_3000)
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Flush,
    input  logic                       Stall,
    input  logic                       In_Valid,
    input  logic [DATA_W-1:0]          In_Pc,
    input  logic [NUM_OPS*DATA_W-1:0]  In_Ops,
    input  logic [DATA_W-1:0]          In_Imm,
    input  logic [NUM_OPS*REG_W-1:0]   In_Src,
    input  logic [REG_W-1:0]           In_Dst,
    input  logic [CTRL_W-1:0]          In_Ctrl,
    input  logic [NUM_OPS*T_W-1:0]     In_Tuse,
    input  logic [T_W-1:0]             In_Tnew,
    input  logic [NUM_OPS-1:0]         Fwd_Valid,
    input  logic [NUM_OPS*DATA_W-1:0]  Fwd_Data,
    output logic                       Out_Valid,
    output logic [DATA_W-1:0]          Out_Pc,
    output logic [NUM_OPS*DATA_W-1:0]  Out_Ops,
    output logic [DATA_W-1:0]          Out_Imm,
    output logic [NUM_OPS*REG_W-1:0]   Out_Src,
    output logic [REG_W-1:0]           Out_Dst,
    output logic [CTRL_W-1:0]          Out_Ctrl,
    output logic [NUM_OPS*T_W-1:0]     Out_Tuse,
    output logic [T_W-1:0]             Out_Tnew,
    output logic [CNT_W-1:0]           Stall_Cnt,
    output logic [CNT_W-1:0]           Bubble_Cnt
);

    logic                       r_valid;
    logic [DATA_W-1:0]          r_pc;
    logic [NUM_OPS*DATA_W-1:0]  r_ops;
    logic [DATA_W-1:0]          r_imm;
    logic [NUM_OPS*REG_W-1:0]   r_src;
    logic [REG_W-1:0]           r_dst;
    logic [CTRL_W-1:0]          r_ctrl;
    logic [NUM_OPS*T_W-1:0]     r_tuse;
    logic [T_W-1:0]             r_tnew;
    logic [CNT_W-1:0]           r_stall_cnt;
    logic [CNT_W-1:0]           r_bubble_cnt;

    logic [T_W-1:0]             w_tnew_dec;
    logic [CNT_W-1:0]           w_stall_cnt_inc;
    logic [CNT_W-1:0]           w_bubble_cnt_inc;

    // Tnew counts down one stage per hop and must never wrap below zero.
    assign w_tnew_dec       = (In_Tnew == '0) ? '0 : In_Tnew - T_W'(1);
    assign w_stall_cnt_inc  = (&r_stall_cnt)  ? r_stall_cnt  : r_stall_cnt  + CNT_W'(1);
    assign w_bubble_cnt_inc = (&r_bubble_cnt) ? r_bubble_cnt : r_bubble_cnt + CNT_W'(1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_valid      <= 1'b0;
            r_pc         <= PC_RESET;
            r_ops        <= '0;
            r_imm        <= '0;
            r_src        <= '0;
            r_dst        <= '0;
            r_ctrl       <= '0;
            r_tuse       <= '0;
            r_tnew       <= '0;
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (Flush) begin
            // PC survives the bubble so EPC/debug still see where it came from.
            r_valid      <= 1'b0;
            r_pc         <= In_Pc;
            r_ops        <= '0;
            r_imm        <= '0;
            r_src        <= '0;
            r_dst        <= '0;
            r_ctrl       <= '0;
            r_tuse       <= '0;
            r_tnew       <= '0;
            r_bubble_cnt <= w_bubble_cnt_inc;
        end else if (Stall) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                if (r_valid && Fwd_Valid[i]) begin
                    r_ops[i*DATA_W +: DATA_W] <= Fwd_Data[i*DATA_W +: DATA_W];
                end
            end
            r_stall_cnt <= w_stall_cnt_inc;
        end else begin
            r_valid <= In_Valid;
            r_pc    <= In_Pc;
            if (In_Valid) begin
                r_ops  <= In_Ops;
                r_imm  <= In_Imm;
                r_src  <= In_Src;
                r_dst  <= In_Dst;
                r_ctrl <= In_Ctrl;
                r_tuse <= In_Tuse;
                r_tnew <= w_tnew_dec;
            end else begin
                r_ops  <= '0;
                r_imm  <= '0;
                r_src  <= '0;
                r_dst  <= '0;
                r_ctrl <= '0;
                r_tuse <= '0;
                r_tnew <= '0;
            end
        end
    end

    assign Out_Valid  = r_valid;
    assign Out_Pc     = r_pc;
    assign Out_Ops    = r_ops;
    assign Out_Imm    = r_imm;
    assign Out_Src    = r_src;
    assign Out_Dst    = r_dst;
    assign Out_Ctrl   = r_ctrl;
    assign Out_Tuse   = r_tuse;
    assign Out_Tnew   = r_tnew;
    assign Stall_Cnt  = r_stall_cnt;
    assign Bubble_Cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboarded bench for pipe_stage_reg: default instance plus a CNT_W=2 instance for saturation.
module tb_pipe_stage_reg;

    logic        Clk = 1'b0;
    logic        Reset, Flush, Stall, In_Valid;
    logic [31:0] In_Pc, In_Imm;
    logic [63:0] In_Ops, Fwd_Data;
    logic [9:0]  In_Src;
    logic [4:0]  In_Dst;
    logic [15:0] In_Ctrl;
    logic [3:0]  In_Tuse;
    logic [1:0]  In_Tnew, Fwd_Valid;

    logic        Out_Valid;
    logic [31:0] Out_Pc, Out_Imm;
    logic [63:0] Out_Ops;
    logic [9:0]  Out_Src;
    logic [4:0]  Out_Dst;
    logic [15:0] Out_Ctrl;
    logic [3:0]  Out_Tuse;
    logic [1:0]  Out_Tnew;
    logic [7:0]  Stall_Cnt, Bubble_Cnt;

    logic        o2_Valid;
    logic [31:0] o2_Pc, o2_Imm;
    logic [63:0] o2_Ops;
    logic [9:0]  o2_Src;
    logic [4:0]  o2_Dst;
    logic [15:0] o2_Ctrl;
    logic [3:0]  o2_Tuse;
    logic [1:0]  o2_Tnew, o2_Stall_Cnt, o2_Bubble_Cnt;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [63:0] ops;
        logic [31:0] imm;
        logic [9:0]  src;
        logic [4:0]  dst;
        logic [15:0] ctrl;
        logic [3:0]  tuse;
        logic [1:0]  tnew;
        logic [7:0]  scnt;
        logic [7:0]  bcnt;
    } snap_t;

    snap_t exp_q[$];
    int    cnt_q[$];
    snap_t e, want, got;
    int    checks = 0;
    int    errors = 0;

    always #5 Clk = ~Clk;

    pipe_stage_reg dut (
        .Clk(Clk), .Reset(Reset), .Flush(Flush), .Stall(Stall), .In_Valid(In_Valid),
        .In_Pc(In_Pc), .In_Ops(In_Ops), .In_Imm(In_Imm), .In_Src(In_Src), .In_Dst(In_Dst),
        .In_Ctrl(In_Ctrl), .In_Tuse(In_Tuse), .In_Tnew(In_Tnew),
        .Fwd_Valid(Fwd_Valid), .Fwd_Data(Fwd_Data),
        .Out_Valid(Out_Valid), .Out_Pc(Out_Pc), .Out_Ops(Out_Ops), .Out_Imm(Out_Imm),
        .Out_Src(Out_Src), .Out_Dst(Out_Dst), .Out_Ctrl(Out_Ctrl), .Out_Tuse(Out_Tuse),
        .Out_Tnew(Out_Tnew), .Stall_Cnt(Stall_Cnt), .Bubble_Cnt(Bubble_Cnt)
    );

    pipe_stage_reg #(.CNT_W(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .Flush(Flush), .Stall(Stall), .In_Valid(In_Valid),
        .In_Pc(In_Pc), .In_Ops(In_Ops), .In_Imm(In_Imm), .In_Src(In_Src), .In_Dst(In_Dst),
        .In_Ctrl(In_Ctrl), .In_Tuse(In_Tuse), .In_Tnew(In_Tnew),
        .Fwd_Valid(Fwd_Valid), .Fwd_Data(Fwd_Data),
        .Out_Valid(o2_Valid), .Out_Pc(o2_Pc), .Out_Ops(o2_Ops), .Out_Imm(o2_Imm),
        .Out_Src(o2_Src), .Out_Dst(o2_Dst), .Out_Ctrl(o2_Ctrl), .Out_Tuse(o2_Tuse),
        .Out_Tnew(o2_Tnew), .Stall_Cnt(o2_Stall_Cnt), .Bubble_Cnt(o2_Bubble_Cnt)
    );

    function automatic snap_t get_snap();
        snap_t s;
        s.valid = Out_Valid;  s.pc   = Out_Pc;   s.ops  = Out_Ops;  s.imm  = Out_Imm;
        s.src   = Out_Src;    s.dst  = Out_Dst;  s.ctrl = Out_Ctrl; s.tuse = Out_Tuse;
        s.tnew  = Out_Tnew;   s.scnt = Stall_Cnt; s.bcnt = Bubble_Cnt;
        return s;
    endfunction

    function automatic snap_t zero_payload(snap_t s, logic [31:0] pc);
        snap_t r = s;
        r.valid = 1'b0; r.pc = pc; r.ops = '0; r.imm = '0; r.src = '0;
        r.dst = '0; r.ctrl = '0; r.tuse = '0; r.tnew = '0;
        return r;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1; Flush = 1; Stall = 1; In_Valid = 1;
        In_Pc = 32'h1234_5678; In_Ops = {2{32'hFFFF_FFFF}}; In_Imm = 32'h55; In_Src = 10'h3FF;
        In_Dst = 5'h1F; In_Ctrl = 16'hFFFF; In_Tuse = 4'hF; In_Tnew = 2'd3;
        Fwd_Valid = 2'b11; Fwd_Data = {2{32'hCAFE_F00D}};
        e = '0; e.pc = 32'h0000_3000;
        exp_q.push_back(e);
        tick();
        got = get_snap(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++; $display("FAIL reset: got %h expected %h", got, want);
        end
    endtask

    task automatic test_load_tnew();
        logic [1:0] tin [3];
        logic [1:0] tout[3];
        tin  = '{2'd2, 2'd0, 2'd3};
        tout = '{2'd1, 2'd0, 2'd2};
        Reset = 0; Flush = 0; Stall = 0; In_Valid = 1;
        In_Pc = 32'h0000_3004; In_Ops = {32'd7, 32'd5}; In_Imm = 32'h0000_1234;
        In_Src = {5'd3, 5'd2}; In_Dst = 5'd9; In_Ctrl = 16'hBEEF; In_Tuse = 4'b0110;
        Fwd_Valid = 2'b11; Fwd_Data = {32'hDEAD_0001, 32'hDEAD_0000};
        for (int k = 0; k < 3; k++) begin
            In_Tnew = tin[k];
            e.valid = 1; e.pc = 32'h0000_3004; e.ops = {32'd7, 32'd5}; e.imm = 32'h0000_1234;
            e.src = {5'd3, 5'd2}; e.dst = 5'd9; e.ctrl = 16'hBEEF; e.tuse = 4'b0110; e.tnew = tout[k];
            exp_q.push_back(e);
            tick();
            got = get_snap(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL load_tnew[%0d]: got %h expected %h", k, got, want);
            end
        end
    endtask

    task automatic test_stall_refresh();
        Stall = 1;
        Fwd_Data = {32'h0000_ABCD, 32'h0000_1111};
        for (int c = 0; c < 3; c++) begin
            In_Pc = 32'h5000 + 32'(c); In_Ops = {$urandom, $urandom}; In_Imm = $urandom;
            In_Src = 10'($urandom); In_Dst = 5'($urandom); In_Ctrl = 16'($urandom);
            In_Tuse = 4'($urandom); In_Tnew = 2'(c); In_Valid = c[0];
            Fwd_Valid = (c == 1) ? 2'b10 : 2'b00;
            e.scnt = e.scnt + 8'd1;
            if (c == 1) e.ops[63:32] = 32'h0000_ABCD;
            exp_q.push_back(e);
            tick();
            got = get_snap(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL stall_refresh[%0d]: got %h expected %h", c, got, want);
            end
        end
    endtask

    task automatic test_flush_with_stall();
        Stall = 1; Flush = 1; In_Valid = 1; In_Pc = 32'h0000_3010;
        In_Ctrl = 16'hFFFF; In_Ops = {32'd1, 32'd2}; Fwd_Valid = 2'b11;
        e = zero_payload(e, 32'h0000_3010);
        e.bcnt = e.bcnt + 8'd1;
        exp_q.push_back(e);
        tick();
        got = get_snap(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++; $display("FAIL flush_with_stall: got %h expected %h", got, want);
        end
    endtask

    task automatic test_back_to_back();
        Flush = 0; Stall = 0;
        for (int k = 0; k < 8; k++) begin
            In_Valid = (k % 3 != 2); In_Pc = 32'h0000_4000 + 32'(4 * k);
            In_Ops = {$urandom, $urandom}; In_Imm = $urandom; In_Src = 10'($urandom);
            In_Dst = 5'($urandom); In_Ctrl = 16'($urandom) | 16'h1; In_Tuse = 4'($urandom);
            In_Tnew = 2'(k); Fwd_Valid = 2'b11; Fwd_Data = {$urandom, $urandom};
            if (In_Valid) begin
                e.valid = 1; e.pc = In_Pc; e.ops = In_Ops; e.imm = In_Imm; e.src = In_Src;
                e.dst = In_Dst; e.ctrl = In_Ctrl; e.tuse = In_Tuse;
                e.tnew = (In_Tnew == 2'd0) ? 2'd0 : In_Tnew - 2'd1;
            end else begin
                e = zero_payload(e, In_Pc);
            end
            exp_q.push_back(e);
            tick();
            got = get_snap(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL back_to_back[%0d]: got %h expected %h", k, got, want);
            end
        end
    endtask

    task automatic test_bubble_load();
        Flush = 0; Stall = 0; In_Valid = 0; In_Pc = 32'h0000_3020;
        In_Ops = {32'd1, 32'd2}; In_Ctrl = 16'h00FF; In_Imm = 32'h77; In_Dst = 5'd4; In_Tnew = 2'd3;
        e = zero_payload(e, 32'h0000_3020);
        exp_q.push_back(e);
        tick();
        got = get_snap(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++; $display("FAIL bubble_load: got %h expected %h", got, want);
        end
        Stall = 1; Fwd_Valid = 2'b11; Fwd_Data = {32'h9999_0001, 32'h9999_0000}; In_Pc = 32'h6000;
        e.scnt = e.scnt + 8'd1;
        exp_q.push_back(e);
        tick();
        got = get_snap(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++; $display("FAIL bubble_stall_no_refresh: got %h expected %h", got, want);
        end
    endtask

    task automatic test_counter_saturate();
        int exp_cnt;
        Reset = 1; Flush = 0; Stall = 0; Fwd_Valid = 2'b00;
        tick();
        Reset = 0; Stall = 1;
        for (int k = 1; k <= 6; k++) begin
            cnt_q.push_back((k > 3) ? 3 : k);
            In_Pc = 32'h7000 + 32'(k);
            tick();
            exp_cnt = cnt_q.pop_front(); checks++;
            if (o2_Stall_Cnt !== 2'(exp_cnt)) begin
                errors++; $display("FAIL sat_stall_cnt[%0d]: got %0d expected %0d", k, o2_Stall_Cnt, exp_cnt);
            end
            checks++;
            if (Stall_Cnt !== 8'(k)) begin
                errors++; $display("FAIL wide_stall_cnt[%0d]: got %0d expected %0d", k, Stall_Cnt, k);
            end
        end
        Reset = 1; Flush = 1;
        e = '0; e.pc = 32'h0000_3000;
        exp_q.push_back(e);
        tick();
        checks++;
        if (o2_Stall_Cnt !== 2'd0 || o2_Pc !== 32'h0000_3000) begin
            errors++; $display("FAIL reset_in_stall: got cnt=%0d pc=%h expected cnt=0 pc=00003000", o2_Stall_Cnt, o2_Pc);
        end
        got = get_snap(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++; $display("FAIL reset_in_stall_full: got %h expected %h", got, want);
        end
        Reset = 0; Flush = 0; Stall = 0;
    endtask

    initial begin
        test_reset();
        test_load_tnew();
        test_stall_refresh();
        test_flush_with_stall();
        test_back_to_back();
        test_bubble_load();
        test_counter_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
